instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage directly upstream of IMEM: owns the program counter, drives PC_Out
//  into IMEM and captures the combinational instruction word returned for it.
//  Buffers fetched {pc, instr} pairs in a small FIFO with valid/ready handshake
//  toward decode, and accepts branch/jump redirects from execute that flush it.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset
//  FQ_DEPTH   2              fetch-queue entries; power of two, >= 2
// PORTS
//  clk             in   1   single clock, all state updates on posedge
//  rst             in   1   asynchronous, active-high reset
//  PC_Out          out  32  current fetch address, to IMEM (word-aligned)
//  instruction     in   32  IMEM read data for PC_Out, same cycle (combinational)
//  redirect_valid  in   1   execute requests PC change (taken branch/jump)
//  redirect_pc     in   32  redirect target
//  out_valid       out  1   head entry of fetch queue is valid
//  out_ready       in   1   decode accepts head entry this cycle
//  out_instr       out  32  head instruction; 32'h0 when out_valid=0
//  out_pc          out  32  PC of head instruction; 32'h0 when out_valid=0
//  misalign_err    out  1   sticky: a redirect target had pc[1:0] != 0
// BEHAVIOUR
//  Reset (async, immediate): PC_Out=RESET_PC, queue count=0, rd/wr ptrs=0,
//   out_valid=0, out_instr=0, out_pc=0, misalign_err=0. Reset mid-operation
//   discards all queued entries; fetch resumes from RESET_PC after deassertion.
//  pop  = out_valid & out_ready.
//  push = ~redirect_valid & (count < FQ_DEPTH | pop).
//  On push: entry {PC_Out, instruction} written at wr ptr; PC_Out <= PC_Out+4.
//  Full with simultaneous pop: push permitted; count unchanged.
//  Full without pop: no push, PC_Out holds (stall); IMEM re-read same address.
//  Empty: out_valid=0; out_ready ignored; pop cannot occur.
//  Redirect (redirect_valid=1) has priority over push and pop: queue flushed
//   (count=0, ptrs=0), PC_Out <= {redirect_pc[31:2],2'b00}; nothing pushed or
//   popped that cycle. If redirect_pc[1:0]!=0, misalign_err <= 1 (cleared only
//   by rst).
//  Latency: instruction at address A appears on out_instr/out_pc the cycle after
//   PC_Out=A was pushed; sustained throughput 1 instr/cycle with out_ready=1.
//  After redirect: out_valid=0 for exactly one cycle, then target entry at head.
//  PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000.
//  Ptrs wrap modulo FQ_DEPTH; count in [0, FQ_DEPTH].
//  instruction value 32'h0 (NOP) is queued like any other word; no decoding here.
//  out_valid/out_instr/out_pc derived from registered queue state only (no
//   combinational path from instruction or out_ready to outputs).
// TESTING
//  1 Reset release, out_ready=1, IMEM words W0..W5 -> out_pc 0,4,8,... one per
//    cycle starting cycle 1; out_instr matches IMEM[out_pc/4].
//  2 out_ready=0 from reset -> after 2 cycles out_valid=1, out_pc=0, PC_Out holds
//    8; then out_ready=1 -> out_pc 0,4,8 on consecutive cycles, no gap or dup.
//  3 Queue full, out_ready=1 for one cycle -> pop+push same cycle, count stays 2,
//    PC_Out advances 8->12, out_pc 0->4.
//  4 Queue full, redirect_valid=1, redirect_pc=32'h14 -> next cycle out_valid=0,
//    PC_Out=32'h14; following cycle out_pc=32'h14; misalign_err=0.
//  5 redirect_pc=32'h16 -> PC_Out=32'h14, misalign_err=1 and stays 1 across
//    later fetches until rst.
//  6 Redirect to 32'hFFFF_FFFC then run -> out_pc FFFF_FFFC then 0000_0000;
//    assert rst mid-stream -> out_valid=0, PC_Out=RESET_PC same cycle.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch
// Description : Fetch stage sitting directly in front of IMEM.
//               Owns the program counter and presents it on PC_Out.
//               Captures the combinational IMEM word returned for that
//               address. Buffers {pc, instr} pairs in a small FIFO with a
//               valid/ready handshake toward decode. Accepts redirects from
//               execute, which flush the FIFO.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   RESET_PC        PC loaded on reset
//   FQ_DEPTH        fetch-queue entries (power of two, >= 2)
// Ports
//   clk             in   1   clock, all state updates on posedge
//   rst             in   1   asynchronous active-high reset
//   PC_Out          out  32  current fetch address to IMEM (word aligned)
//   instruction     in   32  IMEM read data for PC_Out (same cycle)
//   redirect_valid  in   1   execute requests a PC change
//   redirect_pc     in   32  redirect target
//   out_valid       out  1   head entry of fetch queue is valid
//   out_ready       in   1   decode accepts head entry this cycle
//   out_instr       out  32  head instruction, 0 when out_valid=0
//   out_pc          out  32  head PC, 0 when out_valid=0
//   misalign_err    out  1   sticky flag: a redirect target was misaligned
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] PC_Out,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        misalign_err
);

    localparam int unsigned PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] C_DEPTH   = CNT_W'(FQ_DEPTH);
    localparam logic [PTR_W-1:0] C_PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [31:0]      pc_q,       pc_d;
    logic [CNT_W-1:0] count_q,    count_d;
    logic [PTR_W-1:0] wr_ptr_q,   wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,   rd_ptr_d;
    logic             misalign_q, misalign_d;

    logic [31:0]      fq_pc_q    [FQ_DEPTH];
    logic [31:0]      fq_pc_d    [FQ_DEPTH];
    logic [31:0]      fq_instr_q [FQ_DEPTH];
    logic [31:0]      fq_instr_d [FQ_DEPTH];

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic w_head_valid;
    logic w_pop;
    logic w_push;
    logic w_misaligned_target;

    // Head validity comes only from registered count, so no combinational
    // path exists from instruction/out_ready to the decode-facing outputs.
    assign w_head_valid = (count_q != '0);
    assign w_pop        = w_head_valid & out_ready;

    // A full queue can still accept a new word when the head leaves in the
    // same cycle; this is what sustains one instruction per cycle.
    assign w_push = ~redirect_valid & ((count_q < C_DEPTH) | w_pop);

    assign w_misaligned_target = redirect_valid & (redirect_pc[1:0] != 2'b00);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        pc_d       = pc_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        misalign_d = misalign_q | w_misaligned_target;

        if (redirect_valid) begin
            // Redirect wins over push and pop: drop everything in flight and
            // restart fetch at the word-aligned target.
            pc_d     = {redirect_pc[31:2], 2'b00};
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (w_push) begin
                // 32-bit add wraps naturally at the top of the address space.
                pc_d     = pc_q + 32'd4;
                wr_ptr_d = wr_ptr_q + C_PTR_ONE;
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + C_PTR_ONE;
            end
            unique case ({w_push, w_pop})
                2'b10:   count_d = count_q + C_CNT_ONE;
                2'b01:   count_d = count_q - C_CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Queue storage: only the slot under the write pointer changes on a push.
    always_comb begin
        for (int i = 0; i < int'(FQ_DEPTH); i++) begin
            fq_pc_d[i]    = fq_pc_q[i];
            fq_instr_d[i] = fq_instr_q[i];
        end
        if (w_push) begin
            fq_pc_d[wr_ptr_q]    = pc_q;
            fq_instr_d[wr_ptr_q] = instruction;
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            misalign_q <= misalign_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FQ_DEPTH); i++) begin
                fq_pc_q[i]    <= '0;
                fq_instr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(FQ_DEPTH); i++) begin
                fq_pc_q[i]    <= fq_pc_d[i];
                fq_instr_q[i] <= fq_instr_d[i];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign PC_Out       = pc_q;
    assign out_valid    = w_head_valid;
    assign out_instr    = w_head_valid ? fq_instr_q[rd_ptr_q] : 32'h0;
    assign out_pc       = w_head_valid ? fq_pc_q[rd_ptr_q]    : 32'h0;
    assign misalign_err = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch
// Description : Directed self-checking bench for instr_fetch.
//               Uses a behavioural IMEM: word at address A is ~A, except
//               address 0x18, which returns a NOP (32'h0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

    logic        clk;
    logic        rst;
    logic [31:0] PC_Out;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_err;

    int n_checks;
    int n_fail;

    instr_fetch #(
        .RESET_PC (32'h0000_0000),
        .FQ_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .PC_Out         (PC_Out),
        .instruction    (instruction),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .misalign_err   (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] imem_word(input logic [31:0] addr);
        return (addr == 32'h18) ? 32'h0 : ~addr;
    endfunction

    assign instruction = imem_word(PC_Out);

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset pulse applied between edges.
    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_valid", {31'b0, out_valid}, 32'h0);
        check_eq("rst_pc",    PC_Out,             32'h0);
        check_eq("rst_opc",   out_pc,             32'h0);
        check_eq("rst_oinst", out_instr,          32'h0);
        check_eq("rst_mis",   {31'b0, misalign_err}, 32'h0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        out_ready      = 1'b0;
        #2;

        // ---- 1: streaming from reset with decode always ready ----
        out_ready = 1'b1;
        do_reset();
        check_eq("t1_c0_valid", {31'b0, out_valid}, 32'h0);
        for (int i = 0; i < 7; i++) begin
            tick();
            check_eq("t1_valid", {31'b0, out_valid}, 32'h1);
            check_eq("t1_pc",    out_pc,    32'(4 * i));
            check_eq("t1_instr", out_instr, imem_word(32'(4 * i)));
        end
        check_eq("t1_nop", out_instr, 32'h0);  // address 0x18 is a NOP

        // ---- 2: fill with decode stalled, then drain ----
        out_ready = 1'b0;
        do_reset();
        tick();
        tick();
        check_eq("t2_valid",  {31'b0, out_valid}, 32'h1);
        check_eq("t2_opc",    out_pc, 32'h0);
        check_eq("t2_pc",     PC_Out, 32'h8);
        tick();
        check_eq("t2_hold",   PC_Out, 32'h8);
        check_eq("t2_opc_h",  out_pc, 32'h0);
        out_ready = 1'b1;
        tick();
        check_eq("t2_opc4",   out_pc, 32'h4);
        tick();
        check_eq("t2_opc8",   out_pc, 32'h8);

        // ---- 3: pop and push together while full ----
        out_ready = 1'b0;
        do_reset();
        tick();
        tick();
        check_eq("t3_pc8",    PC_Out, 32'h8);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("t3_pc12",   PC_Out, 32'hC);
        check_eq("t3_opc4",   out_pc, 32'h4);
        tick();
        // Still full (count 2): PC must stall and head must stay put.
        check_eq("t3_stall",  PC_Out, 32'hC);
        check_eq("t3_opc4h",  out_pc, 32'h4);

        // ---- 4: aligned redirect on a full queue ----
        redirect_valid = 1'b1;
        redirect_pc    = 32'h14;
        tick();
        redirect_valid = 1'b0;
        check_eq("t4_valid0", {31'b0, out_valid}, 32'h0);
        check_eq("t4_pc",     PC_Out, 32'h14);
        check_eq("t4_oinst0", out_instr, 32'h0);
        tick();
        check_eq("t4_valid1", {31'b0, out_valid}, 32'h1);
        check_eq("t4_opc",    out_pc, 32'h14);
        check_eq("t4_oinst",  out_instr, imem_word(32'h14));
        check_eq("t4_mis",    {31'b0, misalign_err}, 32'h0);

        // ---- 5: misaligned redirect sets sticky error ----
        redirect_valid = 1'b1;
        redirect_pc    = 32'h16;
        tick();
        redirect_valid = 1'b0;
        check_eq("t5_pc",     PC_Out, 32'h14);
        check_eq("t5_mis",    {31'b0, misalign_err}, 32'h1);
        check_eq("t5_valid0", {31'b0, out_valid}, 32'h0);
        out_ready = 1'b1;
        tick();
        check_eq("t5_opc14",  out_pc, 32'h14);
        tick();
        check_eq("t5_opc18",  out_pc, 32'h18);
        check_eq("t5_nop",    out_instr, 32'h0);
        check_eq("t5_mis_st", {31'b0, misalign_err}, 32'h1);

        // ---- 6: wrap at top of address space, then mid-stream reset ----
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        check_eq("t6_pc",     PC_Out, 32'hFFFF_FFFC);
        tick();
        check_eq("t6_opc_top", out_pc, 32'hFFFF_FFFC);
        check_eq("t6_oi_top",  out_instr, 32'h0000_0003);
        check_eq("t6_pc_wrap", PC_Out, 32'h0);
        tick();
        check_eq("t6_opc_0",   out_pc, 32'h0);
        check_eq("t6_oi_0",    out_instr, 32'hFFFF_FFFF);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_valid", {31'b0, out_valid}, 32'h0);
        check_eq("t6_rst_pc",    PC_Out, 32'h0);
        check_eq("t6_rst_mis",   {31'b0, misalign_err}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        check_eq("t6_resume_v",  {31'b0, out_valid}, 32'h1);
        check_eq("t6_resume",    out_pc, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
